// File: rtl/w_ram_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : w_ram_sched_if
//  Description : Bundle of the sweep control, row stream, host write and
//                w_RAM port signals of the weight-RAM scheduler.
//                slave  = scheduler view, master = environment view.
//  Ports       : sweep_*   sweep start/status
//                row_*     ready/valid row stream to the compute engine
//                host_wr_* host weight-load write channel
//                ram_*     single-port w_RAM command/data
//  Revision    : 1.0  initial release
// ============================================================================
interface w_ram_sched_if #(
  parameter int MAX_NEURONS = 8,
  parameter int WEIGHT_W    = 16,
  parameter int ROW_W       = MAX_NEURONS * WEIGHT_W
);
  logic             sweep_start;
  logic [31:0]      sweep_layer;
  logic [31:0]      sweep_count;
  logic             sweep_busy;
  logic             sweep_done;
  logic             sweep_err;
  logic             row_valid;
  logic             row_ready;
  logic [ROW_W-1:0] row_data;
  logic [31:0]      row_neuron;
  logic             host_wr_req;
  logic [31:0]      host_wr_layer;
  logic [31:0]      host_wr_neuron;
  logic [ROW_W-1:0] host_wr_data;
  logic             host_wr_ack;
  logic             host_wr_err;
  logic             ram_rw;
  logic [31:0]      ram_layer;
  logic [31:0]      ram_neuron;
  logic [ROW_W-1:0] ram_w_in;
  logic [ROW_W-1:0] ram_w_out;

  modport slave (
    input  sweep_start, sweep_layer, sweep_count, row_ready,
           host_wr_req, host_wr_layer, host_wr_neuron, host_wr_data, ram_w_out,
    output sweep_busy, sweep_done, sweep_err, row_valid, row_data, row_neuron,
           host_wr_ack, host_wr_err, ram_rw, ram_layer, ram_neuron, ram_w_in
  );

  modport master (
    output sweep_start, sweep_layer, sweep_count, row_ready,
           host_wr_req, host_wr_layer, host_wr_neuron, host_wr_data, ram_w_out,
    input  sweep_busy, sweep_done, sweep_err, row_valid, row_data, row_neuron,
           host_wr_ack, host_wr_err, ram_rw, ram_layer, ram_neuron, ram_w_in
  );
endinterface
`default_nettype wire

// File: rtl/w_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module      : w_ram_sched
//  Description : Sequencer/arbiter in front of the single-port weight RAM.
//                Streams rows 0..count-1 of one layer to the compute engine
//                and interleaves host weight writes into the same RAM port,
//                at most one RAM op per cycle (round-robin when contested).
//  Ports       : CLK    clock, rising edge
//                RST_N  synchronous active-low reset
//                bus    w_ram_sched_if.slave (sweep, row stream, host, RAM)
//  Revision    : 1.0  initial release
// ============================================================================
module w_ram_sched #(
  parameter int MAX_DEPTH   = 4,
  parameter int MAX_NEURONS = 8,
  parameter int WEIGHT_W    = 16,
  parameter int ROW_W       = MAX_NEURONS * WEIGHT_W
) (
  input  logic         CLK,
  input  logic         RST_N,
  w_ram_sched_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      layer_q, layer_d;
  logic [31:0]      count_q, count_d;
  logic [31:0]      idx_q, idx_d;            // next neuron to read
  logic             inflight_q, inflight_d;  // read issued last cycle
  logic [31:0]      inflight_nrn_q, inflight_nrn_d;
  logic [ROW_W-1:0] fifo_data_q [0:1];
  logic [ROW_W-1:0] fifo_data_d [0:1];
  logic [31:0]      fifo_nrn_q [0:1];
  logic [31:0]      fifo_nrn_d [0:1];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  logic             prio_host_q, prio_host_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             start_ok;
  logic             host_in_range;
  logic             host_ok;
  logic             pop;
  logic [1:0]       occ_after;
  logic             rd_elig;
  logic             grant_host;
  logic             grant_rd;

  always_comb begin
    state_d        = state_q;
    layer_d        = layer_q;
    count_d        = count_q;
    idx_d          = idx_q;
    inflight_d     = 1'b0;
    inflight_nrn_d = inflight_nrn_q;
    fifo_data_d    = fifo_data_q;
    fifo_nrn_d     = fifo_nrn_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    prio_host_d    = prio_host_q;
    done_d         = 1'b0;
    err_d          = 1'b0;

    start_ok      = (bus.sweep_layer < 32'(MAX_DEPTH)) && (bus.sweep_count != 32'd0) &&
                    (bus.sweep_count <= 32'(MAX_NEURONS));
    host_in_range = (bus.host_wr_layer < 32'(MAX_DEPTH)) &&
                    (bus.host_wr_neuron < 32'(MAX_NEURONS));
    host_ok       = RST_N && bus.host_wr_req && host_in_range;
    pop           = RST_N && (fifo_cnt_q != 2'd0) && bus.row_ready;
    // Occupancy once this cycle's capture and pop settle; a read issued now
    // lands one cycle later, so it must fit behind that.
    occ_after     = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    rd_elig       = RST_N && (state_q == ST_SWEEP) && (occ_after < 2'd2);
    grant_host    = host_ok && (!rd_elig || prio_host_q);
    grant_rd      = rd_elig && !grant_host;
    if (host_ok && rd_elig) begin
      prio_host_d = ~prio_host_q;
    end

    // Registered RAM data of last cycle's read goes straight into the FIFO.
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = bus.ram_w_out;
      fifo_nrn_d[wr_ptr_q]  = inflight_nrn_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    fifo_cnt_d = occ_after;

    if (grant_rd) begin
      inflight_d     = 1'b1;
      inflight_nrn_d = idx_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (bus.sweep_start) begin
          if (start_ok) begin
            state_d = ST_SWEEP;
            layer_d = bus.sweep_layer;
            count_d = bus.sweep_count;
            idx_d   = 32'd0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SWEEP: begin
        if (grant_rd) begin
          idx_d = idx_q + 32'd1;
          if (idx_q + 32'd1 == count_q) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!inflight_q && (occ_after == 2'd0)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are forced low while reset is held, whatever the inputs do.
    bus.sweep_busy  = RST_N && (state_q != ST_IDLE);
    bus.sweep_done  = RST_N && done_q;
    bus.sweep_err   = RST_N && err_q;
    bus.row_valid   = RST_N && (fifo_cnt_q != 2'd0);
    bus.row_data    = bus.row_valid ? fifo_data_q[rd_ptr_q] : '0;
    bus.row_neuron  = bus.row_valid ? fifo_nrn_q[rd_ptr_q] : 32'd0;
    bus.host_wr_ack = grant_host;
    bus.host_wr_err = RST_N && bus.host_wr_req && !host_in_range;
    bus.ram_rw      = grant_host;
    bus.ram_layer   = grant_host ? bus.host_wr_layer  : (grant_rd ? layer_q : 32'd0);
    bus.ram_neuron  = grant_host ? bus.host_wr_neuron : (grant_rd ? idx_q   : 32'd0);
    bus.ram_w_in    = grant_host ? bus.host_wr_data   : '0;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q        <= ST_IDLE;
      layer_q        <= 32'd0;
      count_q        <= 32'd0;
      idx_q          <= 32'd0;
      inflight_q     <= 1'b0;
      inflight_nrn_q <= 32'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= '0;
        fifo_nrn_q[i]  <= 32'd0;
      end
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      fifo_cnt_q     <= 2'd0;
      prio_host_q    <= 1'b1;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      layer_q        <= layer_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      inflight_q     <= inflight_d;
      inflight_nrn_q <= inflight_nrn_d;
      fifo_data_q    <= fifo_data_d;
      fifo_nrn_q     <= fifo_nrn_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_cnt_q     <= fifo_cnt_d;
      prio_host_q    <= prio_host_d;
      done_q         <= done_d;
      err_q          <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_w_ram_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_w_ram_sched
//  Description : Self-checking bench for w_ram_sched with a behavioural
//                single-port w_RAM (registered read) and a row scoreboard.
//  Ports       : none
//  Revision    : 1.0  initial release
// ============================================================================
module tb_w_ram_sched;
  localparam int MAX_DEPTH   = 4;
  localparam int MAX_NEURONS = 8;
  localparam int WEIGHT_W    = 16;
  localparam int ROW_W       = MAX_NEURONS * WEIGHT_W;

  typedef struct packed {
    logic [31:0]      nrn;
    logic [ROW_W-1:0] data;
  } row_t;

  logic             CLK = 1'b0;
  logic             RST_N;
  logic             ram_init;
  int               n_vec = 0;
  int               n_bad = 0;
  row_t             exp_q [$];
  logic [ROW_W-1:0] exp_mem [0:31];
  logic [ROW_W-1:0] mem [0:31];
  logic [4:0]       ridx;

  w_ram_sched_if #(.MAX_NEURONS(MAX_NEURONS), .WEIGHT_W(WEIGHT_W)) bus ();

  w_ram_sched #(
    .MAX_DEPTH(MAX_DEPTH), .MAX_NEURONS(MAX_NEURONS), .WEIGHT_W(WEIGHT_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus.slave)
  );

  always #5 CLK = ~CLK;

  function automatic logic [ROW_W-1:0] pat(input int i);
    logic [ROW_W-1:0] r;
    for (int w = 0; w < MAX_NEURONS; w++) r[w*WEIGHT_W +: WEIGHT_W] = 16'(i * 256 + w * 17 + 3);
    return r;
  endfunction

  // Behavioural w_RAM: write or registered read, one op per edge.
  assign ridx = {bus.ram_layer[1:0], bus.ram_neuron[2:0]};
  always @(posedge CLK) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= pat(i);
      bus.ram_w_out <= '0;
    end else if (bus.ram_rw) begin
      mem[ridx] <= bus.ram_w_in;
    end else begin
      bus.ram_w_out <= mem[ridx];
    end
  end

  task automatic chk(input string nm, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_idle();
    bus.sweep_start = 1'b0; bus.sweep_layer = 32'd0; bus.sweep_count = 32'd0;
    bus.row_ready = 1'b0; bus.host_wr_req = 1'b0; bus.host_wr_layer = 32'd0;
    bus.host_wr_neuron = 32'd0; bus.host_wr_data = '0;
  endtask

  task automatic push_sweep(input int l, input int c);
    row_t e;
    for (int n = 0; n < c; n++) begin
      e.nrn  = 32'(n);
      e.data = exp_mem[l * 8 + n];
      exp_q.push_back(e);
    end
  endtask

  task automatic start_sweep(input int l, input int c);
    bus.sweep_start = 1'b1; bus.sweep_layer = 32'(l); bus.sweep_count = 32'(c);
  endtask

  task automatic wait_done(input string nm, input int budget);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge CLK);
      if (bus.sweep_done) begin
        seen = 1'b1;
        chk("done_busy_low", bus.sweep_busy, 1'b0);
        break;
      end
    end
    chk(nm, seen, 1'b1);
    step();
  endtask

  initial begin
    logic             seen;
    logic             ack_s;
    int               hn;
    logic [ROW_W-1:0] hd;
    logic [ROW_W-1:0] a5;

    set_idle();
    RST_N    = 1'b0;
    ram_init = 1'b1;
    for (int i = 0; i < 32; i++) exp_mem[i] = pat(i);

    fork
      begin : monitor
        forever begin
          @(negedge CLK);
          if (bus.row_valid && bus.row_ready) begin
            if (exp_q.size() == 0) begin
              chk("row_unexpected", 1'b1, 1'b0);
            end else begin
              row_t e;
              e = exp_q.pop_front();
              chk("row_neuron", bus.row_neuron, e.nrn);
              chk("row_data", bus.row_data, e.data);
            end
          end
        end
      end
      begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    // 1: reset with random inputs
    repeat (2) begin
      step();
      bus.sweep_start = 1'($urandom_range(0, 1)); bus.sweep_layer = $urandom;
      bus.sweep_count = 32'($urandom_range(0, 9)); bus.row_ready = 1'($urandom_range(0, 1));
      bus.host_wr_req = 1'b1; bus.host_wr_layer = 32'($urandom_range(0, 3));
      bus.host_wr_neuron = 32'($urandom_range(0, 7)); bus.host_wr_data = {4{$urandom}};
      @(negedge CLK);
      chk("rst_outputs", {bus.sweep_busy, bus.sweep_done, bus.sweep_err, bus.row_valid,
                          bus.host_wr_ack, bus.host_wr_err, bus.ram_rw, |bus.row_data,
                          |bus.row_neuron, |bus.ram_layer, |bus.ram_neuron, |bus.ram_w_in}, 12'd0);
    end
    step();
    set_idle();
    RST_N = 1'b1; ram_init = 1'b0;
    @(negedge CLK);
    chk("idle_after_rst", {bus.sweep_busy, bus.row_valid, bus.ram_rw}, 3'b000);

    // 2: host write L1 N2, then sweep L1 count 3
    a5 = {8{16'hA5A5}};
    step();
    bus.host_wr_req = 1'b1; bus.host_wr_layer = 32'd1; bus.host_wr_neuron = 32'd2;
    bus.host_wr_data = a5;
    @(negedge CLK);
    chk("wr_ack", bus.host_wr_ack, 1'b1);
    chk("wr_rw", bus.ram_rw, 1'b1);
    chk("wr_addr", {bus.ram_layer, bus.ram_neuron}, {32'd1, 32'd2});
    chk("wr_data", bus.ram_w_in, a5);
    exp_mem[1 * 8 + 2] = a5;
    step();
    bus.host_wr_req = 1'b0;
    @(negedge CLK);
    chk("wr_one_cycle", {bus.host_wr_ack, bus.ram_rw}, 2'b00);
    step();
    start_sweep(1, 3); bus.row_ready = 1'b1;
    push_sweep(1, 3);
    step();
    bus.sweep_start = 1'b0;
    @(negedge CLK);
    chk("lat_k1", {bus.sweep_busy, bus.row_valid}, 2'b10);
    step();
    @(negedge CLK);
    chk("lat_k2", bus.row_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge CLK);
      chk("b2b_valid", bus.row_valid, 1'b1);
      if (i == 2) chk("row2_a5", {bus.row_neuron, bus.row_data}, {32'd2, a5});
    end
    step();
    @(negedge CLK);
    chk("done_pulse", {bus.sweep_done, bus.sweep_busy}, 2'b10);
    step();
    @(negedge CLK);
    chk("done_once", bus.sweep_done, 1'b0);

    // 3: sweep L0 count 8 with a 10-cycle consumer stall
    step();
    start_sweep(0, 8);
    push_sweep(0, 8);
    step();
    bus.sweep_start = 1'b0;
    repeat (4) step();
    bus.row_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (i == 0 || i == 9) chk("stall_hold_row2", {bus.row_valid, bus.row_neuron}, {1'b1, 32'd2});
      step();
    end
    bus.row_ready = 1'b1;
    wait_done("sweep8_done", 40);
    chk("sb_drained_t3", exp_q.size(), 0);

    // 4: host writes to L3 held during sweep L2 count 8 -> W,R,W,R...
    start_sweep(2, 8);
    push_sweep(2, 8);
    step();
    bus.sweep_start = 1'b0;
    hn = 0; hd = {8{16'(16'h5A00 + hn)}};
    bus.host_wr_req = 1'b1; bus.host_wr_layer = 32'd3; bus.host_wr_neuron = 32'(hn);
    bus.host_wr_data = hd;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge CLK);
      if (c < 6) begin
        chk("alt_rw", bus.ram_rw, (c % 2 == 0));
        if (c % 2 == 1) chk("alt_rd_addr", {bus.ram_layer, bus.ram_neuron}, {32'd2, 32'(c / 2)});
      end
      ack_s = bus.host_wr_ack;
      if (bus.sweep_done) seen = 1'b1;
      step();
      if (ack_s) begin
        exp_mem[3 * 8 + hn] = hd;
        hn = (hn + 1) % 8;
        hd = {8{16'(16'h5A00 + hn + 16 * c)}};
        bus.host_wr_neuron = 32'(hn); bus.host_wr_data = hd;
      end
    end
    bus.host_wr_req = 1'b0;
    chk("alt_done", seen, 1'b1);
    chk("sb_drained_t4", exp_q.size(), 0);

    // 5: out-of-range host writes and rejected starts
    bus.host_wr_req = 1'b1; bus.host_wr_layer = 32'd0; bus.host_wr_neuron = 32'd8;
    @(negedge CLK);
    chk("werr_nrn", {bus.host_wr_err, bus.host_wr_ack, bus.ram_rw}, 3'b100);
    step();
    bus.host_wr_layer = 32'd4; bus.host_wr_neuron = 32'd0;
    @(negedge CLK);
    chk("werr_layer", {bus.host_wr_err, bus.host_wr_ack, bus.ram_rw}, 3'b100);
    step();
    bus.host_wr_req = 1'b0;
    @(negedge CLK);
    chk("werr_clear", bus.host_wr_err, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      case (i)
        0:       start_sweep(0, 0);
        1:       start_sweep(4, 1);
        default: start_sweep(0, 9);
      endcase
      step();
      bus.sweep_start = 1'b0;
      @(negedge CLK);
      chk("sweep_err", {bus.sweep_err, bus.sweep_busy, bus.ram_rw}, 3'b100);
      step();
      @(negedge CLK);
      chk("sweep_err_pulse", {bus.sweep_err, bus.sweep_busy, bus.row_valid}, 3'b000);
    end

    // 6: reset after row 3 accepted, then a clean sweep of L3
    step();
    start_sweep(0, 8);
    push_sweep(0, 8);
    step();
    bus.sweep_start = 1'b0;
    repeat (5) step();
    @(negedge CLK);
    step();
    chk("rows_left_at_rst", exp_q.size(), 4);
    exp_q.delete();
    RST_N = 1'b0;
    @(negedge CLK);
    chk("rst_mid_quiet", {bus.row_valid, bus.sweep_busy, bus.sweep_done}, 3'b000);
    step();
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_rst_quiet", {bus.row_valid, bus.sweep_busy, bus.sweep_done}, 3'b000);
      step();
    end
    start_sweep(3, 4);
    push_sweep(3, 4);
    step();
    bus.sweep_start = 1'b0;
    wait_done("resweep_done", 30);
    chk("sb_final_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
